host_job_ctrl: RTL and testbench



---
 rtl/host_job_ctrl.sv | 271 +++++++++++++++++++++++++++
 tb/tb_host_job_ctrl.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/host_job_ctrl.sv
// Host mailbox job controller: START/ACK handshake, arbitrated core access to the shared
// memory port, per-channel result addressing and repeated DONE flag writes.
// Optional watchdog with error flag write enabled by defining HOST_JOB_WDOG_EN.
module host_job_ctrl #(
    parameter int                ADDR_W      = 21,
    parameter int                NUM_CHAN    = 4,
    parameter int                IDX_W       = 2,
    parameter logic [ADDR_W-1:0] RESULT_BASE = 21'h03CF96,
    parameter logic [ADDR_W-1:0] ACK_ADDR    = 21'h000000,
    parameter logic [ADDR_W-1:0] DONE_ADDR   = 21'h07FFFE,
    parameter logic [31:0]       START_FLAG  = 32'h0001_0000,
    parameter logic [31:0]       ACK_FLAG    = 32'h0000_0002,
    parameter logic [31:0]       DONE_FLAG   = 32'h0000_0004,
    parameter int                DONE_REPEAT = 3,
    parameter int                SWAP_BYTES  = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [31:0]                 host_flag_in,
    output logic                        flag_we,
    output logic [31:0]                 flag_out,
    output logic                        mem_req,
    output logic                        mem_wr_en,
    output logic [ADDR_W-1:0]           mem_addr,
    output logic [31:0]                 mem_wdata,
    input  logic [31:0]                 mem_rdata,
    input  logic                        mem_rd_ready,
    output logic                        core_start,
    input  logic                        core_req,
    input  logic                        core_rd_wr,
    input  logic [ADDR_W-1:0]           core_addr,
    input  logic [$clog2(NUM_CHAN)-1:0] core_chan,
    input  logic [IDX_W-1:0]            core_idx,
    input  logic [31:0]                 core_wdata,
    output logic [31:0]                 core_rdata,
    output logic                        core_rdata_valid,
    input  logic                        core_done,
    output logic [15:0]                 job_count,
    output logic                        busy
);

    localparam int CNT_W = (DONE_REPEAT > 1) ? $clog2(DONE_REPEAT) : 1;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ACK     = 3'd1,
        RUN     = 3'd2,
        RD_WAIT = 3'd3,
`ifdef HOST_JOB_WDOG_EN
        DONE_WR = 3'd4,
        ERR_WR  = 3'd5
`else
        DONE_WR = 3'd4
`endif
    } state_t;

    state_t             state_reg, state_next;
    logic               armed_reg, armed_next;
    logic [CNT_W-1:0]   done_cnt_reg, done_cnt_next;
    logic [15:0]        job_count_reg, job_count_next;
`ifdef HOST_JOB_WDOG_EN
    logic [15:0]        wdog_reg, wdog_next;
`endif

    logic               flag_we_reg, flag_we_next;
    logic [31:0]        flag_out_reg, flag_out_next;
    logic               mem_req_reg, mem_req_next;
    logic               mem_wr_en_reg, mem_wr_en_next;
    logic [ADDR_W-1:0]  mem_addr_reg, mem_addr_next;
    logic [31:0]        mem_wdata_reg, mem_wdata_next;
    logic               core_start_reg, core_start_next;
    logic [31:0]        core_rdata_reg, core_rdata_next;
    logic               core_rdata_valid_reg, core_rdata_valid_next;
    logic               busy_reg, busy_next;

    logic [31:0]        wdata_sw;
    logic [31:0]        rdata_sw;
    logic [ADDR_W-1:0]  result_addr;

    // Memory is big-endian relative to the core when swapping is enabled.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_swap
            if (SWAP_BYTES != 0) begin : g_rev
                assign wdata_sw[8*gi +: 8] = core_wdata[8*(3-gi) +: 8];
                assign rdata_sw[8*gi +: 8] = mem_rdata[8*(3-gi) +: 8];
            end else begin : g_thru
                assign wdata_sw[8*gi +: 8] = core_wdata[8*gi +: 8];
                assign rdata_sw[8*gi +: 8] = mem_rdata[8*gi +: 8];
            end
        end
    endgenerate

    // {chan, idx} is exactly chan * 2**IDX_W + idx.
    assign result_addr = RESULT_BASE + ADDR_W'({core_chan, core_idx});

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            armed_reg     <= 1'b1;
            done_cnt_reg  <= '0;
            job_count_reg <= '0;
`ifdef HOST_JOB_WDOG_EN
            wdog_reg      <= '0;
`endif
        end else begin
            state_reg     <= state_next;
            armed_reg     <= armed_next;
            done_cnt_reg  <= done_cnt_next;
            job_count_reg <= job_count_next;
`ifdef HOST_JOB_WDOG_EN
            wdog_reg      <= wdog_next;
`endif
        end
    end

    always_comb begin
        state_next     = state_reg;
        armed_next     = armed_reg;
        done_cnt_next  = done_cnt_reg;
        job_count_next = job_count_reg;
`ifdef HOST_JOB_WDOG_EN
        wdog_next      = wdog_reg;
`endif
        case (state_reg)
            IDLE: begin
                // A START left over from the previous job must drop before it counts again.
                if (armed_reg && host_flag_in == START_FLAG) begin
                    state_next = ACK;
                end else if (!armed_reg && host_flag_in != START_FLAG) begin
                    armed_next = 1'b1;
                end
            end
            ACK: begin
                state_next = RUN;
`ifdef HOST_JOB_WDOG_EN
                wdog_next  = '0;
`endif
            end
            RUN: begin
                if (core_done) begin
                    state_next    = DONE_WR;
                    done_cnt_next = '0;
                end else if (core_req) begin
                    if (!core_rd_wr) begin
                        state_next = RD_WAIT;
                    end
`ifdef HOST_JOB_WDOG_EN
                    wdog_next = '0;
                end else if (wdog_reg == 16'hFFFE) begin
                    state_next = ERR_WR;
                end else begin
                    wdog_next = wdog_reg + 16'd1;
`endif
                end
            end
            RD_WAIT: begin
                if (mem_rd_ready) begin
                    state_next = RUN;
`ifdef HOST_JOB_WDOG_EN
                    wdog_next  = '0;
                end else if (wdog_reg == 16'hFFFE) begin
                    state_next = ERR_WR;
                end else begin
                    wdog_next = wdog_reg + 16'd1;
`endif
                end
            end
            DONE_WR: begin
                if (done_cnt_reg == CNT_W'(DONE_REPEAT - 1)) begin
                    state_next     = IDLE;
                    armed_next     = 1'b0;
                    done_cnt_next  = '0;
                    job_count_next = job_count_reg + 16'd1;
                end else begin
                    done_cnt_next = done_cnt_reg + 1'b1;
                end
            end
`ifdef HOST_JOB_WDOG_EN
            ERR_WR: begin
                state_next = IDLE;
                armed_next = 1'b0;
            end
`endif
            default: state_next = IDLE;
        endcase
    end

    // Outputs are decided from the transition being taken so they line up with the new state.
    always_comb begin
        flag_we_next          = 1'b0;
        flag_out_next         = '0;
        mem_req_next          = 1'b0;
        mem_wr_en_next        = 1'b0;
        mem_addr_next         = '0;
        mem_wdata_next        = '0;
        core_start_next       = (state_next == RUN);
        core_rdata_next       = core_rdata_reg;
        core_rdata_valid_next = 1'b0;
        busy_next             = (state_next != IDLE);
        case (state_next)
            ACK: begin
                flag_we_next  = 1'b1;
                flag_out_next = ACK_FLAG;
                mem_addr_next = ACK_ADDR;
            end
            DONE_WR: begin
                flag_we_next  = 1'b1;
                flag_out_next = DONE_FLAG;
                mem_addr_next = DONE_ADDR;
            end
`ifdef HOST_JOB_WDOG_EN
            ERR_WR: begin
                flag_we_next  = 1'b1;
                flag_out_next = 32'h0000_0008;
                mem_addr_next = DONE_ADDR;
            end
`endif
            default: ;
        endcase
        if (state_reg == RUN && core_req && !core_done) begin
            mem_req_next   = 1'b1;
            mem_wr_en_next = core_rd_wr;
            mem_addr_next  = core_rd_wr ? result_addr : core_addr;
            mem_wdata_next = core_rd_wr ? wdata_sw : 32'h0;
        end
        if (state_reg == RD_WAIT && mem_rd_ready) begin
            core_rdata_next       = rdata_sw;
            core_rdata_valid_next = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            flag_we_reg          <= 1'b0;
            flag_out_reg         <= '0;
            mem_req_reg          <= 1'b0;
            mem_wr_en_reg        <= 1'b0;
            mem_addr_reg         <= '0;
            mem_wdata_reg        <= '0;
            core_start_reg       <= 1'b0;
            core_rdata_reg       <= '0;
            core_rdata_valid_reg <= 1'b0;
            busy_reg             <= 1'b0;
        end else begin
            flag_we_reg          <= flag_we_next;
            flag_out_reg         <= flag_out_next;
            mem_req_reg          <= mem_req_next;
            mem_wr_en_reg        <= mem_wr_en_next;
            mem_addr_reg         <= mem_addr_next;
            mem_wdata_reg        <= mem_wdata_next;
            core_start_reg       <= core_start_next;
            core_rdata_reg       <= core_rdata_next;
            core_rdata_valid_reg <= core_rdata_valid_next;
            busy_reg             <= busy_next;
        end
    end

    assign flag_we          = flag_we_reg;
    assign flag_out         = flag_out_reg;
    assign mem_req          = mem_req_reg;
    assign mem_wr_en        = mem_wr_en_reg;
    assign mem_addr         = mem_addr_reg;
    assign mem_wdata        = mem_wdata_reg;
    assign core_start       = core_start_reg;
    assign core_rdata       = core_rdata_reg;
    assign core_rdata_valid = core_rdata_valid_reg;
    assign job_count        = job_count_reg;
    assign busy             = busy_reg;

endmodule

// File: tb/tb_host_job_ctrl.sv
// Directed bench for host_job_ctrl: a per-cycle expectation schedule filled from the
// behavioural rules, checked every cycle, plus literal spot checks.
module tb_host_job_ctrl;

    localparam int          N      = 48;
    localparam int          LAST   = 40;
    localparam logic [20:0] R_BASE = 21'h03CF96;
    localparam logic [20:0] A_ADDR = 21'h000000;
    localparam logic [20:0] D_ADDR = 21'h07FFFE;
    localparam logic [31:0] START  = 32'h0001_0000;
    localparam logic [31:0] ACKF   = 32'h0000_0002;
    localparam logic [31:0] DONEF  = 32'h0000_0004;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] host_flag_in;
    logic        flag_we;
    logic [31:0] flag_out;
    logic        mem_req;
    logic        mem_wr_en;
    logic [20:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_rd_ready;
    logic        core_start;
    logic        core_req;
    logic        core_rd_wr;
    logic [20:0] core_addr;
    logic [1:0]  core_chan;
    logic [1:0]  core_idx;
    logic [31:0] core_wdata;
    logic [31:0] core_rdata;
    logic        core_rdata_valid;
    logic        core_done;
    logic [15:0] job_count;
    logic        busy;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    logic        exp_fwe   [N];
    logic [31:0] exp_fout  [N];
    logic        exp_mreq  [N];
    logic        exp_wren  [N];
    logic [20:0] exp_addr  [N];
    logic [31:0] exp_wdata [N];
    logic        exp_start [N];
    logic        exp_busy  [N];
    logic [15:0] exp_job   [N];
    logic        exp_valid [N];
    logic [31:0] exp_rdata [N];

    host_job_ctrl dut (
        .clk(clk), .rst(rst), .host_flag_in(host_flag_in),
        .flag_we(flag_we), .flag_out(flag_out),
        .mem_req(mem_req), .mem_wr_en(mem_wr_en), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_rd_ready(mem_rd_ready),
        .core_start(core_start), .core_req(core_req), .core_rd_wr(core_rd_wr),
        .core_addr(core_addr), .core_chan(core_chan), .core_idx(core_idx),
        .core_wdata(core_wdata), .core_rdata(core_rdata),
        .core_rdata_valid(core_rdata_valid), .core_done(core_done),
        .job_count(job_count), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] swap32(input logic [31:0] x);
        logic [31:0] r;
        r = {<<8{x}};
        return r;
    endfunction

    task automatic cmp(input int c, input string name, input logic [31:0] got,
                       input logic [31:0] expv);
        n_checks++;
        if (got !== expv) begin
            n_errors++;
            $display("FAIL cyc=%0d %s got=%h expected=%h", c, name, got, expv);
        end
    endtask

    task automatic wait_cyc(input int c);
        while (cyc != c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic exp_flag(input int c, input logic [31:0] v, input logic [20:0] a);
        exp_fwe[c] = 1'b1; exp_fout[c] = v; exp_addr[c] = a;
    endtask

    task automatic exp_mem(input int c, input logic wr, input logic [20:0] a,
                           input logic [31:0] d);
        exp_mreq[c] = 1'b1; exp_wren[c] = wr; exp_addr[c] = a; exp_wdata[c] = d;
    endtask

    task automatic start_from(input int c, input logic v);
        for (int i = c; i < N; i++) exp_start[i] = v;
    endtask
    task automatic busy_from(input int c, input logic v);
        for (int i = c; i < N; i++) exp_busy[i] = v;
    endtask
    task automatic job_from(input int c, input logic [15:0] v);
        for (int i = c; i < N; i++) exp_job[i] = v;
    endtask
    task automatic rdata_from(input int c, input logic [31:0] v);
        for (int i = c; i < N; i++) exp_rdata[i] = v;
    endtask

    always @(negedge clk) begin
        if (cyc >= 1 && cyc <= LAST) begin
            cmp(cyc, "flag_we", 32'(flag_we), 32'(exp_fwe[cyc]));
            cmp(cyc, "flag_out", flag_out, exp_fout[cyc]);
            cmp(cyc, "mem_req", 32'(mem_req), 32'(exp_mreq[cyc]));
            cmp(cyc, "mem_wr_en", 32'(mem_wr_en), 32'(exp_wren[cyc]));
            cmp(cyc, "mem_addr", 32'(mem_addr), 32'(exp_addr[cyc]));
            cmp(cyc, "mem_wdata", mem_wdata, exp_wdata[cyc]);
            cmp(cyc, "core_start", 32'(core_start), 32'(exp_start[cyc]));
            cmp(cyc, "busy", 32'(busy), 32'(exp_busy[cyc]));
            cmp(cyc, "job_count", 32'(job_count), 32'(exp_job[cyc]));
            cmp(cyc, "rdata_valid", 32'(core_rdata_valid), 32'(exp_valid[cyc]));
            cmp(cyc, "core_rdata", core_rdata, exp_rdata[cyc]);
        end
    end

    initial begin
        logic [1:0]  wch [4];
        logic [1:0]  wid [4];
        logic [31:0] wdat[4];
        wch  = '{2'd2, 2'd0, 2'd3, 2'd1};
        wid  = '{2'd1, 2'd0, 2'd3, 2'd2};
        wdat = '{32'h11223344, 32'hA5A5_0001, 32'hDEAD_BEEF, 32'h0000_00FF};

        for (int i = 0; i < N; i++) begin
            exp_fwe[i] = 0; exp_fout[i] = 0; exp_mreq[i] = 0; exp_wren[i] = 0;
            exp_addr[i] = 0; exp_wdata[i] = 0; exp_start[i] = 0; exp_busy[i] = 0;
            exp_job[i] = 0; exp_valid[i] = 0; exp_rdata[i] = 0;
        end
        rst = 1'b1; host_flag_in = 0; mem_rdata = 0; mem_rd_ready = 0;
        core_req = 0; core_rd_wr = 0; core_addr = 0; core_chan = 0; core_idx = 0;
        core_wdata = 0; core_done = 0;

        wait_cyc(2);
        rst = 1'b0;

        wait_cyc(3);
        $display("[%0d] host START", cyc);
        host_flag_in = START;
        exp_flag(4, ACKF, A_ADDR); busy_from(4, 1); start_from(5, 1);
        wait_cyc(4);
        cmp(cyc, "lit_ack_flag", flag_out, 32'h2);
        cmp(cyc, "lit_ack_addr", 32'(mem_addr), 32'h0);

        for (int i = 0; i < 4; i++) begin
            wait_cyc(5 + i);
            if (i == 1) begin
                cmp(cyc, "lit_wr_addr", 32'(mem_addr), 32'h03CF9F);
                cmp(cyc, "lit_wr_data", mem_wdata, 32'h44332211);
            end
            $display("[%0d] write ch=%0d idx=%0d data=%h", cyc, wch[i], wid[i], wdat[i]);
            core_req = 1; core_rd_wr = 1; core_chan = wch[i]; core_idx = wid[i];
            core_wdata = wdat[i];
            exp_mem(6 + i, 1'b1, 21'(R_BASE + 21'(wch[i]) * 21'd4 + 21'(wid[i])),
                    swap32(wdat[i]));
        end

        wait_cyc(9);
        $display("[%0d] read addr=%h", cyc, 21'h00100);
        core_rd_wr = 0; core_addr = 21'h00100;
        exp_mem(10, 1'b0, 21'h00100, 32'h0); start_from(10, 0);
        wait_cyc(12);
        mem_rd_ready = 1; mem_rdata = 32'hAABBCCDD;
        exp_valid[13] = 1; rdata_from(13, swap32(32'hAABBCCDD)); start_from(13, 1);
        wait_cyc(13);
        cmp(cyc, "lit_rdata", core_rdata, 32'hDDCCBBAA);
        core_req = 0; mem_rd_ready = 0; mem_rdata = 0;

        wait_cyc(14);
        $display("[%0d] core_done with write request", cyc);
        core_done = 1; core_req = 1; core_rd_wr = 1;
        for (int c = 15; c <= 17; c++) exp_flag(c, DONEF, D_ADDR);
        start_from(15, 0); busy_from(18, 0); job_from(18, 16'd1);
        wait_cyc(15);
        core_done = 0; core_req = 0;
        wait_cyc(19);
        cmp(cyc, "lit_job_count", 32'(job_count), 32'd1);

        wait_cyc(21);
        $display("[%0d] host flag drops", cyc);
        host_flag_in = 0;
        wait_cyc(22);
        $display("[%0d] host START again", cyc);
        host_flag_in = START;
        exp_flag(23, ACKF, A_ADDR); busy_from(23, 1); start_from(24, 1);

        wait_cyc(25);
        $display("[%0d] read addr=%h then reset", cyc, 21'h0002A);
        core_req = 1; core_rd_wr = 0; core_addr = 21'h0002A;
        exp_mem(26, 1'b0, 21'h0002A, 32'h0); start_from(26, 0);
        wait_cyc(26);
        core_req = 0;
        wait_cyc(27);
        rst = 1; host_flag_in = 0;
        busy_from(28, 0); job_from(28, 16'd0); rdata_from(28, 32'h0); start_from(28, 0);
        wait_cyc(28);
        cmp(cyc, "lit_busy_rst", 32'(busy), 32'd0);
        rst = 0; mem_rd_ready = 1; mem_rdata = 32'h12345678;
        wait_cyc(29);
        mem_rd_ready = 0;

        wait_cyc(30);
        $display("[%0d] host START after reset", cyc);
        host_flag_in = START;
        exp_flag(31, ACKF, A_ADDR); busy_from(31, 1); start_from(32, 1);
        wait_cyc(32);
        $display("[%0d] core_done", cyc);
        core_done = 1;
        for (int c = 33; c <= 35; c++) exp_flag(c, DONEF, D_ADDR);
        start_from(33, 0); busy_from(36, 0); job_from(36, 16'd1);
        wait_cyc(33);
        core_done = 0; host_flag_in = 0;

        wait_cyc(LAST + 1);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
